wb_regfile_hilo: RTL and testbench

Writeback-stage consumer of the X3→WB pipeline register: selects the writeback value, commits it to the 32×32 general register file, updates the Hi/Lo pair from ALU or multiply-add results, and commits SAD min-value/index results. It sits at the end of the pipeline and feeds the decode stage through two bypassed read ports, plus Hi/Lo read-outs. It also counts retired instructions.

---
 rtl/wb_regfile_hilo.sv | 78 +++++++
 tb/tb_wb_regfile_hilo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_hilo.sv
// wb_regfile_hilo: writeback select, 32x32 register file with Hi/Lo, bypassed reads and retire counter
module wb_regfile_hilo #(
  parameter logic [4:0] MIN_VAL_REG = 5'd2,
  parameter logic [4:0] MIN_IDX_REG = 5'd3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] WB_Instruction,
  input  logic [31:0] WB_PCAdd4,
  input  logic [31:0] WB_DataMemOut,
  input  logic [31:0] WB_ALUOut,
  input  logic [31:0] WB_HiLoOut,
  input  logic [63:0] WB_MaddOut,
  input  logic [4:0]  WB_WriteRegCarry,
  input  logic        WB_MemToReg,
  input  logic        WB_Jal_Mux,
  input  logic        WB_HiLo_WB,
  input  logic        WB_RegWrite,
  input  logic [1:0]  WB_BitsIn,
  input  logic        WB_SEL_Madd,
  input  logic        WB_WriteDataHi,
  input  logic        WB_WriteDataLo,
  input  logic [31:0] WB_minVal,
  input  logic [31:0] WB_sad_add_d0_out,
  input  logic        WB_minRegWrite,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic [31:0] WbData,
  output logic [31:0] RetireCount
);
  logic [31:0] rf [32];
  logic [31:0] hi, lo, cnt, load_val, hi_nxt, lo_nxt;
  logic a_en, v_en, i_en;
  assign a_en = WB_RegWrite && WB_WriteRegCarry != 5'd0;
  assign v_en = WB_minRegWrite && MIN_VAL_REG != 5'd0;
  assign i_en = WB_minRegWrite && MIN_IDX_REG != 5'd0;
  assign hi_nxt = WB_SEL_Madd ? WB_MaddOut[63:32] : WB_ALUOut;
  assign lo_nxt = WB_SEL_Madd ? WB_MaddOut[31:0] : WB_ALUOut;
  assign RetireCount = cnt;
  always_comb begin
    load_val = WB_BitsIn == 2'b00 ? WB_DataMemOut :
               WB_BitsIn == 2'b01 ? {{16{WB_DataMemOut[15]}}, WB_DataMemOut[15:0]} :
               WB_BitsIn == 2'b10 ? {{24{WB_DataMemOut[7]}}, WB_DataMemOut[7:0]} :
                                    {24'd0, WB_DataMemOut[7:0]};
    WbData = WB_Jal_Mux ? WB_PCAdd4 : WB_HiLo_WB ? WB_HiLoOut : WB_MemToReg ? load_val : WB_ALUOut;
  end
  // Min-result port outranks the normal writeback port, both here and in the commit below
  function automatic logic [31:0] rd(input logic [4:0] a);
    return a == 5'd0 ? '0 :
           Reset ? rf[a] :
           (i_en && a == MIN_IDX_REG) ? WB_sad_add_d0_out :
           (v_en && a == MIN_VAL_REG) ? WB_minVal :
           (a_en && a == WB_WriteRegCarry) ? WbData : rf[a];
  endfunction
  assign ReadData1 = rd(ReadReg1);
  assign ReadData2 = rd(ReadReg2);
  assign HiOut = (!Reset && WB_WriteDataHi) ? hi_nxt : hi;
  assign LoOut = (!Reset && WB_WriteDataLo) ? lo_nxt : lo;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
    end else begin
      if (a_en) rf[WB_WriteRegCarry] <= WbData;
      if (v_en) rf[MIN_VAL_REG] <= WB_minVal;
      if (i_en) rf[MIN_IDX_REG] <= WB_sad_add_d0_out;
      if (WB_WriteDataHi) hi <= hi_nxt;
      if (WB_WriteDataLo) lo <= lo_nxt;
      if (WB_Instruction != '0) cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// tb_wb_regfile_hilo: scoreboard bench for the writeback register file, directed plus random cycles
module tb_wb_regfile_hilo;
  logic        Clk = 0, Reset;
  logic [31:0] WB_Instruction, WB_PCAdd4, WB_DataMemOut, WB_ALUOut, WB_HiLoOut;
  logic [63:0] WB_MaddOut;
  logic [4:0]  WB_WriteRegCarry, ReadReg1, ReadReg2;
  logic        WB_MemToReg, WB_Jal_Mux, WB_HiLo_WB, WB_RegWrite;
  logic [1:0]  WB_BitsIn;
  logic        WB_SEL_Madd, WB_WriteDataHi, WB_WriteDataLo, WB_minRegWrite;
  logic [31:0] WB_minVal, WB_sad_add_d0_out;
  logic [31:0] ReadData1, ReadData2, HiOut, LoOut, WbData, RetireCount;
  logic [31:0] m [32];
  logic [31:0] mhi, mlo, mcnt;
  logic [31:0] exp_q [$];
  int n_tests = 0, n_fail = 0;
  wb_regfile_hilo dut (
    .Clk(Clk), .Reset(Reset), .WB_Instruction(WB_Instruction), .WB_PCAdd4(WB_PCAdd4),
    .WB_DataMemOut(WB_DataMemOut), .WB_ALUOut(WB_ALUOut), .WB_HiLoOut(WB_HiLoOut),
    .WB_MaddOut(WB_MaddOut), .WB_WriteRegCarry(WB_WriteRegCarry), .WB_MemToReg(WB_MemToReg),
    .WB_Jal_Mux(WB_Jal_Mux), .WB_HiLo_WB(WB_HiLo_WB), .WB_RegWrite(WB_RegWrite),
    .WB_BitsIn(WB_BitsIn), .WB_SEL_Madd(WB_SEL_Madd), .WB_WriteDataHi(WB_WriteDataHi),
    .WB_WriteDataLo(WB_WriteDataLo), .WB_minVal(WB_minVal), .WB_sad_add_d0_out(WB_sad_add_d0_out),
    .WB_minRegWrite(WB_minRegWrite), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .HiOut(HiOut), .LoOut(LoOut),
    .WbData(WbData), .RetireCount(RetireCount)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_wb();
    logic [31:0] ld;
    case (WB_BitsIn)
      2'b00: ld = WB_DataMemOut;
      2'b01: ld = {{16{WB_DataMemOut[15]}}, WB_DataMemOut[15:0]};
      2'b10: ld = {{24{WB_DataMemOut[7]}}, WB_DataMemOut[7:0]};
      default: ld = {24'd0, WB_DataMemOut[7:0]};
    endcase
    if (WB_Jal_Mux) return WB_PCAdd4;
    if (WB_HiLo_WB) return WB_HiLoOut;
    if (WB_MemToReg) return ld;
    return WB_ALUOut;
  endfunction
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    logic [31:0] v;
    if (a == 0) return 0;
    v = m[a];
    if (Reset) return v;
    if (WB_RegWrite && WB_WriteRegCarry == a) v = m_wb();
    if (WB_minRegWrite && a == 5'd2) v = WB_minVal;
    if (WB_minRegWrite && a == 5'd3) v = WB_sad_add_d0_out;
    return v;
  endfunction
  task automatic cycle();
    logic [31:0] h, l;
    h = (!Reset && WB_WriteDataHi) ? (WB_SEL_Madd ? WB_MaddOut[63:32] : WB_ALUOut) : mhi;
    l = (!Reset && WB_WriteDataLo) ? (WB_SEL_Madd ? WB_MaddOut[31:0] : WB_ALUOut) : mlo;
    exp_q.push_back(m_rd(ReadReg1));
    exp_q.push_back(m_rd(ReadReg2));
    exp_q.push_back(h);
    exp_q.push_back(l);
    exp_q.push_back(m_wb());
    exp_q.push_back(mcnt);
    #1;
    chk("rd1", ReadData1, exp_q.pop_front());
    chk("rd2", ReadData2, exp_q.pop_front());
    chk("hi", HiOut, exp_q.pop_front());
    chk("lo", LoOut, exp_q.pop_front());
    chk("wbdata", WbData, exp_q.pop_front());
    chk("retire", RetireCount, exp_q.pop_front());
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 32; i++) m[i] = 0;
      mhi = 0; mlo = 0; mcnt = 0;
    end else begin
      if (WB_RegWrite && WB_WriteRegCarry != 0) m[WB_WriteRegCarry] = m_wb();
      if (WB_minRegWrite) begin m[2] = WB_minVal; m[3] = WB_sad_add_d0_out; end
      mhi = h; mlo = l;
      if (WB_Instruction != 0) mcnt = mcnt + 1;
    end
    @(negedge Clk);
  endtask
  task automatic idle();
    {WB_Instruction, WB_PCAdd4, WB_DataMemOut, WB_ALUOut, WB_HiLoOut, WB_MaddOut} = '0;
    {WB_WriteRegCarry, WB_MemToReg, WB_Jal_Mux, WB_HiLo_WB, WB_RegWrite, WB_BitsIn} = '0;
    {WB_SEL_Madd, WB_WriteDataHi, WB_WriteDataLo, WB_minVal, WB_sad_add_d0_out, WB_minRegWrite} = '0;
    ReadReg1 = 0; ReadReg2 = 0;
  endtask
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    ReadReg1 = a;
    #1 chk(tag, ReadData1, exp);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m[i] = 0;
    mhi = 0; mlo = 0; mcnt = 0;
    idle();
    Reset = 1;
    @(negedge Clk);
    cycle();
    cycle();
    chk("reset_retire", RetireCount, 0);
    chk("reset_hi", HiOut, 0);
    Reset = 0;
    WB_Instruction = 32'h1; WB_RegWrite = 1; WB_WriteRegCarry = 5; WB_ALUOut = 32'h12345678; ReadReg1 = 5;
    #1 chk("bypass_r5", ReadData1, 32'h12345678);
    cycle();
    idle();
    rd_chk("r5", 5, 32'h12345678);
    chk("retire_one", RetireCount, 1);
    for (int b = 1; b < 4; b++) begin
      WB_MemToReg = 1; WB_RegWrite = 1; WB_DataMemOut = 32'h000080F0;
      WB_BitsIn = 2'(b); WB_WriteRegCarry = 5'(5 + b);
      cycle();
    end
    idle();
    rd_chk("lh", 6, 32'hFFFF80F0);
    rd_chk("lb", 7, 32'hFFFFFFF0);
    rd_chk("lbu", 8, 32'h000000F0);
    WB_Jal_Mux = 1; WB_HiLo_WB = 1; WB_PCAdd4 = 32'h40; WB_HiLoOut = 32'h99; WB_RegWrite = 1; WB_WriteRegCarry = 31;
    cycle();
    idle();
    rd_chk("jal_r31", 31, 32'h40);
    WB_RegWrite = 1; WB_WriteRegCarry = 0; WB_ALUOut = 32'hDEAD; ReadReg1 = 0;
    #1 chk("r0_bypass", ReadData1, 0);
    cycle();
    idle();
    rd_chk("r0", 0, 0);
    WB_SEL_Madd = 1; WB_MaddOut = 64'h00000001_FFFFFFFE; WB_WriteDataHi = 1; WB_WriteDataLo = 1;
    cycle();
    idle();
    #1 chk("madd_hi", HiOut, 1);
    chk("madd_lo", LoOut, 32'hFFFFFFFE);
    WB_WriteDataLo = 1; WB_ALUOut = 7;
    cycle();
    idle();
    #1 chk("alu_lo", LoOut, 7);
    chk("hi_kept", HiOut, 1);
    WB_minRegWrite = 1; WB_minVal = 9; WB_sad_add_d0_out = 4; WB_RegWrite = 1; WB_WriteRegCarry = 2; WB_ALUOut = 32'hAA;
    ReadReg1 = 2; ReadReg2 = 3;
    cycle();
    idle();
    rd_chk("min_r2", 2, 9);
    rd_chk("min_r3", 3, 4);
    for (int n = 0; n < 300; n++) begin
      Reset = ($urandom_range(0, 24) == 0);
      WB_Instruction = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      WB_PCAdd4 = $urandom; WB_DataMemOut = $urandom; WB_ALUOut = $urandom; WB_HiLoOut = $urandom;
      WB_MaddOut = {$urandom, $urandom};
      WB_WriteRegCarry = 5'($urandom); WB_BitsIn = 2'($urandom);
      {WB_MemToReg, WB_Jal_Mux, WB_HiLo_WB, WB_RegWrite} = 4'($urandom);
      {WB_SEL_Madd, WB_WriteDataHi, WB_WriteDataLo} = 3'($urandom);
      WB_minRegWrite = ($urandom_range(0, 5) == 0);
      WB_minVal = $urandom; WB_sad_add_d0_out = $urandom;
      ReadReg1 = ($urandom_range(0, 1) == 1) ? WB_WriteRegCarry : 5'($urandom);
      ReadReg2 = 5'($urandom_range(0, 4));
      cycle();
    end
    Reset = 0;
    idle();
    force dut.cnt = 32'hFFFFFFFF;
    #1 release dut.cnt;
    mcnt = 32'hFFFFFFFF;
    chk("retire_max", RetireCount, 32'hFFFFFFFF);
    WB_Instruction = 32'h8;
    cycle();
    chk("retire_wrap", RetireCount, 0);
    WB_RegWrite = 1; WB_WriteRegCarry = 9; WB_ALUOut = 32'h55; WB_WriteDataHi = 1; ReadReg1 = 9;
    cycle();
    Reset = 1;
    WB_ALUOut = 32'h77;
    #1 chk("rst_nobypass", ReadData1, 32'h55);
    cycle();
    Reset = 0;
    idle();
    rd_chk("rst_r9", 9, 0);
    chk("rst_hi", HiOut, 0);
    chk("rst_retire", RetireCount, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
